// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush control and I/D refill-port arbiter for the 5-stage core.
// Latency: control outputs are combinational from registered state plus current hazard inputs.
// Backpressure: mem_req is held with a stable mem_sel until mem_done; stalls freeze upstream stages meanwhile.
module pipeline_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ic_miss_f,
    input  logic                      dc_miss_m,
    input  logic                      mem_done,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_d,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_d,
    input  logic [REG_ADDR_WIDTH-1:0] rd_e,
    input  logic                      mem_read_e,
    input  logic                      pc_src_e,
    output logic                      stall_f,
    output logic                      stall_d,
    output logic                      stall_e,
    output logic                      stall_m,
    output logic                      flush_d,
    output logic                      flush_e,
    output logic                      redirect_capture,
    output logic                      redirect_apply,
    output logic                      mem_req,
    output logic                      mem_sel,
    output logic [CNT_WIDTH-1:0]      stall_cycles
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        IC_FILL = 2'd1,
        DC_FILL = 2'd2
    } state_t;

    state_t state;
    logic   redirect_pend;
    logic   lu_haz;

    // A load in E whose destination feeds the instruction in D; x0 never creates a dependency.
    assign lu_haz = mem_read_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

    // FSM and redirect bookkeeping: the refill owner only changes once mem_done closes the current fill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= RUN;
            redirect_pend <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    // A pending redirect is consumed in the first RUN cycle after the fill.
                    redirect_pend <= 1'b0;
                    if (dc_miss_m)
                        state <= DC_FILL;
                    else if (pc_src_e)
                        state <= RUN;      // the missing fetch was on the wrong path
                    else if (!lu_haz && ic_miss_f)
                        state <= IC_FILL;
                end
                IC_FILL: begin
                    // The branch target cannot be fetched until the I fill ends, so remember it.
                    if (!dc_miss_m && pc_src_e)
                        redirect_pend <= 1'b1;
                    if (mem_done)
                        state <= dc_miss_m ? DC_FILL : RUN;
                end
                DC_FILL: begin
                    if (mem_done)
                        state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    // Stall/flush/refill outputs; reset forces bubbles into F/D and D/E and drops the refill request.
    always_comb begin
        stall_f          = 1'b0;
        stall_d          = 1'b0;
        stall_e          = 1'b0;
        stall_m          = 1'b0;
        flush_d          = 1'b0;
        flush_e          = 1'b0;
        redirect_capture = 1'b0;
        redirect_apply   = 1'b0;
        mem_req          = 1'b0;
        mem_sel          = 1'b0;
        if (rst) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (dc_miss_m) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        stall_e = 1'b1;
                        stall_m = 1'b1;
                    end else if (pc_src_e) begin
                        flush_d = 1'b1;
                        flush_e = 1'b1;
                    end else if (lu_haz) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_e = 1'b1;
                    end else if (ic_miss_f) begin
                        stall_f = 1'b1;
                        flush_d = 1'b1;
                    end
                    if (redirect_pend) begin
                        redirect_apply = 1'b1;
                        flush_d        = 1'b1;
                    end
                end
                IC_FILL: begin
                    mem_req = 1'b1;
                    mem_sel = 1'b0;
                    stall_f = 1'b1;
                    if (dc_miss_m) begin
                        // Memory stage waits behind the I fill; freeze everything instead of draining.
                        stall_d = 1'b1;
                        stall_e = 1'b1;
                        stall_m = 1'b1;
                    end else begin
                        flush_d = 1'b1;
                        if (pc_src_e) begin
                            flush_e          = 1'b1;
                            redirect_capture = 1'b1;
                        end
                    end
                end
                DC_FILL: begin
                    mem_req = 1'b1;
                    mem_sel = 1'b1;
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    stall_e = 1'b1;
                    stall_m = 1'b1;
                end
                default: begin
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                end
            endcase
        end
    end

    // Performance counter: fetch-stall cycles, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cycles <= '0;
        else if (stall_f && (stall_cycles != {CNT_WIDTH{1'b1}}))
            stall_cycles <= stall_cycles + 1'b1;
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed-vector bench for pipeline_ctrl with a queue-based scoreboard.
// Stimulus pushes expected outputs per cycle; a negedge monitor pops and compares.
// Runs to a single summary line.
module tb_pipeline_ctrl;

    logic        clk;
    logic        rst;
    logic        ic_miss_f;
    logic        dc_miss_m;
    logic        mem_done;
    logic [4:0]  rs1_d;
    logic [4:0]  rs2_d;
    logic [4:0]  rd_e;
    logic        mem_read_e;
    logic        pc_src_e;
    logic        stall_f;
    logic        stall_d;
    logic        stall_e;
    logic        stall_m;
    logic        flush_d;
    logic        flush_e;
    logic        redirect_capture;
    logic        redirect_apply;
    logic        mem_req;
    logic        mem_sel;
    logic [15:0] stall_cycles;

    pipeline_ctrl #(
        .REG_ADDR_WIDTH(5),
        .CNT_WIDTH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ic_miss_f(ic_miss_f),
        .dc_miss_m(dc_miss_m),
        .mem_done(mem_done),
        .rs1_d(rs1_d),
        .rs2_d(rs2_d),
        .rd_e(rd_e),
        .mem_read_e(mem_read_e),
        .pc_src_e(pc_src_e),
        .stall_f(stall_f),
        .stall_d(stall_d),
        .stall_e(stall_e),
        .stall_m(stall_m),
        .flush_d(flush_d),
        .flush_e(flush_e),
        .redirect_capture(redirect_capture),
        .redirect_apply(redirect_apply),
        .mem_req(mem_req),
        .mem_sel(mem_sel),
        .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control bits in order {sf,sd,se,sm, fd,fe, rcap,rapp, mreq,msel}
    logic [9:0]  exp_ctrl_q [$];
    logic [15:0] exp_cnt_q  [$];
    string       name_q     [$];

    int checks = 0;
    int passed = 0;

    // Monitor: compare whatever the stimulus queued for this cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_ctrl_q.size() > 0) begin
                logic [9:0]  ec;
                logic [15:0] en;
                logic [9:0]  act;
                string       nm;
                ec  = exp_ctrl_q.pop_front();
                en  = exp_cnt_q.pop_front();
                nm  = name_q.pop_front();
                act = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e,
                       redirect_capture, redirect_apply, mem_req, mem_sel};
                checks++;
                if (act === ec) passed++;
                else $display("FAIL %s ctrl: got %b expected %b", nm, act, ec);
                checks++;
                if (stall_cycles === en) passed++;
                else $display("FAIL %s stall_cycles: got %0d expected %0d", nm, stall_cycles, en);
            end
        end
    end

    task automatic step(input string nm, input logic r, input logic ic, input logic dc,
                        input logic done, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [4:0] rd, input logic mr, input logic pc,
                        input logic [9:0] ec, input logic [15:0] en);
        @(posedge clk);
        #1;
        rst        = r;
        ic_miss_f  = ic;
        dc_miss_m  = dc;
        mem_done   = done;
        rs1_d      = s1;
        rs2_d      = s2;
        rd_e       = rd;
        mem_read_e = mr;
        pc_src_e   = pc;
        exp_ctrl_q.push_back(ec);
        exp_cnt_q.push_back(en);
        name_q.push_back(nm);
    endtask

    initial begin
        rst = 1'b1; ic_miss_f = 0; dc_miss_m = 0; mem_done = 0;
        rs1_d = 0; rs2_d = 0; rd_e = 0; mem_read_e = 0; pc_src_e = 0;

        //     name           rst ic dc dn rs1 rs2 rd  mr pc  ctrl             cnt
        step("reset",         1, 0, 0, 0, 0,  0,  0,  0, 0, 10'b0000_11_00_00, 16'd0);
        step("idle",          0, 0, 0, 0, 0,  0,  0,  0, 0, 10'b0000_00_00_00, 16'd0);
        // I-miss: one RUN cycle plus four fill cycles of stall_f
        step("imiss_run",     0, 1, 0, 0, 0,  0,  0,  0, 0, 10'b1000_10_00_00, 16'd0);
        step("ifill1",        0, 0, 0, 0, 0,  0,  0,  0, 0, 10'b1000_10_00_10, 16'd1);
        step("ifill2",        0, 0, 0, 0, 0,  0,  0,  0, 0, 10'b1000_10_00_10, 16'd2);
        step("ifill3",        0, 0, 0, 0, 0,  0,  0,  0, 0, 10'b1000_10_00_10, 16'd3);
        step("ifill4_done",   0, 0, 0, 1, 0,  0,  0,  0, 0, 10'b1000_10_00_10, 16'd4);
        step("after_ifill",   0, 0, 0, 0, 0,  0,  0,  0, 0, 10'b0000_00_00_00, 16'd5);
        step("done_in_run",   0, 0, 0, 1, 0,  0,  0,  0, 0, 10'b0000_00_00_00, 16'd5);
        step("idle2",         0, 0, 0, 0, 0,  0,  0,  0, 0, 10'b0000_00_00_00, 16'd5);
        // Load-use hazards
        step("lu_rs1",        0, 0, 0, 0, 5,  0,  5,  1, 0, 10'b1100_01_00_00, 16'd5);
        step("lu_rd0",        0, 0, 0, 0, 0,  0,  0,  1, 0, 10'b0000_00_00_00, 16'd6);
        step("lu_rs2",        0, 0, 0, 0, 3,  7,  7,  1, 0, 10'b1100_01_00_00, 16'd6);
        step("no_load",       0, 0, 0, 0, 3,  7,  7,  0, 0, 10'b0000_00_00_00, 16'd7);
        // Branch wins over load-use and over an I-miss
        step("br_lu",         0, 0, 0, 0, 5,  0,  5,  1, 1, 10'b0000_11_00_00, 16'd7);
        step("br_imiss",      0, 1, 0, 0, 0,  0,  0,  0, 1, 10'b0000_11_00_00, 16'd7);
        step("idle3",         0, 0, 0, 0, 0,  0,  0,  0, 0, 10'b0000_00_00_00, 16'd7);
        // Arbitration: D-miss arrives during an I fill
        step("arb_imiss",     0, 1, 0, 0, 0,  0,  0,  0, 0, 10'b1000_10_00_00, 16'd7);
        step("arb_f1",        0, 0, 0, 0, 0,  0,  0,  0, 0, 10'b1000_10_00_10, 16'd8);
        step("arb_f2_dmiss",  0, 0, 1, 0, 0,  0,  0,  0, 0, 10'b1111_00_00_10, 16'd9);
        step("arb_f3_done",   0, 0, 1, 1, 0,  0,  0,  0, 0, 10'b1111_00_00_10, 16'd10);
        step("arb_dc1",       0, 0, 1, 0, 0,  0,  0,  0, 0, 10'b1111_00_00_11, 16'd11);
        step("arb_dc2_done",  0, 0, 1, 1, 0,  0,  0,  0, 0, 10'b1111_00_00_11, 16'd12);
        step("arb_run",       0, 0, 0, 0, 0,  0,  0,  0, 0, 10'b0000_00_00_00, 16'd13);
        // Branch during an I fill: capture now, apply on return to RUN
        step("bri_imiss",     0, 1, 0, 0, 0,  0,  0,  0, 0, 10'b1000_10_00_00, 16'd13);
        step("bri_capture",   0, 0, 0, 0, 0,  0,  0,  0, 1, 10'b1000_11_10_10, 16'd14);
        step("bri_done",      0, 0, 0, 1, 0,  0,  0,  0, 0, 10'b1000_10_00_10, 16'd15);
        step("bri_apply",     0, 0, 0, 0, 0,  0,  0,  0, 0, 10'b0000_10_01_00, 16'd16);
        step("bri_after",     0, 0, 0, 0, 0,  0,  0,  0, 0, 10'b0000_00_00_00, 16'd16);
        // D-miss from RUN, then async reset in the middle of the D fill
        step("dmiss_run",     0, 0, 1, 0, 0,  0,  0,  0, 0, 10'b1111_00_00_00, 16'd16);
        step("dfill1",        0, 0, 1, 0, 0,  0,  0,  0, 0, 10'b1111_00_00_11, 16'd17);
        step("rst_mid_fill",  1, 0, 1, 0, 0,  0,  0,  0, 0, 10'b0000_11_00_00, 16'd0);
        step("rst_hold",      1, 0, 1, 0, 0,  0,  0,  0, 0, 10'b0000_11_00_00, 16'd0);
        step("post_rst",      0, 0, 0, 0, 0,  0,  0,  0, 0, 10'b0000_00_00_00, 16'd0);
        step("post_rst_lu",   0, 0, 0, 0, 9,  0,  9,  1, 0, 10'b1100_01_00_00, 16'd0);
        step("post_rst_idle", 0, 0, 0, 0, 0,  0,  0,  0, 0, 10'b0000_00_00_00, 16'd1);

        // Let the monitor drain the last entry, bounded
        for (int i = 0; i < 10 && exp_ctrl_q.size() > 0; i++) @(posedge clk);
        if (exp_ctrl_q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d entries left, required 0", exp_ctrl_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush and refill-port arbiter for the 5-stage pipelined-plus-cache core.
- Drives the enable and flush controls of the F/D, D/E and E/M pipeline registers.
- Detects load-use hazards and handles branch redirects.
- Shares the single memory refill port between the I-cache (fetch) and the D-cache (memory stage).
- Sits beside the datapath; all control outputs are combinational from registered state plus current hazard inputs.

Parameters:
REG_ADDR_WIDTH, 5, register specifier width
CNT_WIDTH, 16, width of stall-cycle performance counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
ic_miss_f  input  1  I-cache miss for current fetch
dc_miss_m  input  1  D-cache miss for load/store in M
mem_done  input  1  one-cycle pulse: current refill complete
rs1_d  input  REG_ADDR_WIDTH  source 1 of instruction in D
rs2_d  input  REG_ADDR_WIDTH  source 2 of instruction in D
rd_e  input  REG_ADDR_WIDTH  destination of instruction in E
mem_read_e  input  1  instruction in E is a load
pc_src_e  input  1  taken branch/jump resolved in E
stall_f  output  1  hold PC
stall_d  output  1  hold F/D register
stall_e  output  1  hold D/E register
stall_m  output  1  hold E/M register
flush_d  output  1  clear F/D register (bubble)
flush_e  output  1  clear D/E register (bubble)
redirect_capture  output  1  fetch must latch branch target now
redirect_apply  output  1  fetch must load latched target into PC
mem_req  output  1  refill request, held until mem_done
mem_sel  output  1  refill owner: 0 = I-cache, 1 = D-cache
stall_cycles  output  CNT_WIDTH  saturating count of cycles with stall_f=1

Behaviour:
- Reset (async):
  - State = RUN, redirect_pend = 0, stall_cycles = 0.
  - While rst is high: flush_d = flush_e = 1; all stalls, mem_req, redirect_* = 0.
- FSM states: RUN, IC_FILL, DC_FILL.
- lu_haz = mem_read_e & (rd_e != 0) & (rd_e == rs1_d | rd_e == rs2_d).
- RUN:
  - dc_miss_m: stall_f/d/e/m = 1, flush_e = 0. Next state DC_FILL.
  - else pc_src_e: flush_d = flush_e = 1, no stalls; lu_haz is ignored. Next RUN, even if ic_miss_f.
  - else lu_haz: stall_f = stall_d = 1, flush_e = 1 (one-cycle bubble).
  - else ic_miss_f: stall_f = 1, flush_d = 1. Next IC_FILL.
  - redirect_pend = 1: redirect_apply = 1 and flush_d = 1 this cycle; redirect_pend clears. All other RUN outputs are evaluated normally.
- IC_FILL:
  - mem_req = 1, mem_sel = 0, stall_f = 1, flush_d = 1; downstream drains.
  - dc_miss_m: additionally stall_d/e/m = 1 and flush_d = 0. The I fill is not preempted.
  - pc_src_e (and no dc_miss_m): flush_e = 1, redirect_capture = 1, redirect_pend <= 1.
  - On mem_done: next = DC_FILL if dc_miss_m, else RUN.
- DC_FILL:
  - mem_req = 1, mem_sel = 1, stall_f/d/e/m = 1; no flushes.
  - On mem_done: next = RUN. The re-executed access hits.
- mem_req and mem_sel are stable from request until mem_done inclusive.
- mem_done in RUN is ignored.
- stall_cycles increments each cycle stall_f = 1 and saturates at all-ones.
- Reset asserted mid-fill: mem_req drops immediately; the memory side must abandon the fill.

Test Plan:
- Load-use: mem_read_e=1, rd_e=5, rs1_d=5 in RUN -> one cycle of stall_f=stall_d=1, flush_e=1; rd_e=0 -> no stall.
- Branch with load-use: pc_src_e=1 and lu_haz=1 -> flush_d=flush_e=1, stall_f=0.
- I-miss: ic_miss_f=1 -> IC_FILL, mem_req=1, mem_sel=0, stall_f=1 for 4 cycles; mem_done on cycle 4 -> RUN next cycle; stall_cycles = 5.
- Arbitration: IC_FILL active, dc_miss_m=1 at cycle 2, mem_done at cycle 3 -> stall_f/d/e/m=1 from cycle 2; mem_sel 0->1 in DC_FILL; RUN after second mem_done.
- Branch during I-fill: pc_src_e=1 in IC_FILL -> redirect_capture pulse, flush_e=1; first RUN cycle after fill shows redirect_apply=1, flush_d=1.
- Async reset mid-DC_FILL: rst rises between edges -> mem_req=0 immediately, flush_d=flush_e=1, stall_cycles=0; RUN after release.
